// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared definitions for the IF/MEM RAM port arbiter
//
// Package cpu_defs: arbiter state encoding, default bus widths and the
// byte-enable pattern driven for every read access.
package cpu_defs;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_ISSUE_I = 3'd1;
  localparam logic [ST_W-1:0] ST_ISSUE_D = 3'd2;
  localparam logic [ST_W-1:0] ST_WAIT_I  = 3'd3;
  localparam logic [ST_W-1:0] ST_WAIT_D  = 3'd4;

  // Reads always fetch the full word.
  localparam logic [1:0] RD_BYTE_EN = 2'b11;

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// rtl/mem_port_arbiter_wait_counter.sv - RAM read-latency down-counter
//
// Module arb_wait_counter.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   load   in   grant edge; counter takes MEM_LAT so it holds MEM_LAT in ISSUE
//   done   out  counter is zero; in a WAIT state this marks the ram_rdata cycle
module arb_wait_counter #(
  parameter int MEM_LAT = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int CW = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(MEM_LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port RAM arbiter between IF fetch and MEM load/store
//
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   if_req/if_addr               fetch request, held until if_valid
//   if_rdata/if_valid/if_stall   fetched word, completion pulse, stall to hazard unit
//   mem_req/mem_we/mem_byte_en/mem_addr/mem_wdata  data request, held until mem_valid
//   mem_rdata/mem_valid/mem_stall                  load word, completion pulse, stall
//   ram_en/ram_we/ram_byte_en/ram_addr/ram_wdata   registered RAM command (one cycle/access)
//   ram_rdata                    RAM read data, valid MEM_LAT cycles after ram_en
module mem_port_arbiter
  import cpu_defs::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_byte_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_valid,
  output logic              mem_stall,
  output logic              ram_en,
  output logic              ram_we,
  output logic [1:0]        ram_byte_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  if (MEM_LAT < 1) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT must be >= 1");
  end

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [ST_W-1:0] state;
  logic [SW-1:0]   starve_cnt;
  logic            if_elig;
  logic            mem_elig;
  logic            arb_open;
  logic            grant_i;
  logic            grant_d;
  logic            wait_done;

  assign if_stall = if_req & ~if_valid;
  assign mem_stall = mem_req & ~mem_valid;

  // A requester is still holding its request during its own valid cycle,
  // so that request has already been served.
  assign if_elig  = if_req & ~if_valid;
  assign mem_elig = mem_req & ~mem_valid;

  // The valid cycle is a bubble: no grant is made while either completion
  // pulse is high, so the finished requester gets a chance to re-request
  // before the next arbitration and starvation counting stays meaningful.
  assign arb_open = (state == ST_IDLE) & ~if_valid & ~mem_valid;

  assign grant_i = arb_open & if_elig & (~mem_elig | (starve_cnt == STARVE_LIM));
  assign grant_d = arb_open & mem_elig & ~grant_i;

  arb_wait_counter #(
    .MEM_LAT (MEM_LAT)
  ) u_wait (
    .clock (clock),
    .reset (reset),
    .load  (grant_i | grant_d),
    .done  (wait_done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      starve_cnt  <= '0;
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_byte_en <= 2'b00;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      if_rdata    <= '0;
      mem_rdata   <= '0;
      if_valid    <= 1'b0;
      mem_valid   <= 1'b0;
    end else begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      if_valid  <= 1'b0;
      mem_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (grant_i) begin
            state       <= ST_ISSUE_I;
            ram_en      <= 1'b1;
            ram_byte_en <= RD_BYTE_EN;
            ram_addr    <= if_addr;
            starve_cnt  <= '0;
          end else if (grant_d) begin
            state       <= ST_ISSUE_D;
            ram_en      <= 1'b1;
            ram_we      <= mem_we;
            ram_byte_en <= mem_we ? mem_byte_en : RD_BYTE_EN;
            ram_addr    <= mem_addr;
            ram_wdata   <= mem_wdata;
            if (!if_req) begin
              starve_cnt <= '0;
            end else if (starve_cnt != STARVE_LIM) begin
              starve_cnt <= starve_cnt + SW'(1);
            end
          end
        end

        ST_ISSUE_I: state <= ST_WAIT_I;

        // ram_we is still high in ISSUE_D for a store; a store needs no wait.
        ST_ISSUE_D: begin
          if (ram_we) begin
            state     <= ST_IDLE;
            mem_valid <= 1'b1;
          end else begin
            state <= ST_WAIT_D;
          end
        end

        ST_WAIT_I: begin
          if (wait_done) begin
            if_rdata <= ram_rdata;
            if_valid <= 1'b1;
            state    <= ST_IDLE;
          end
        end

        ST_WAIT_D: begin
          if (wait_done) begin
            mem_rdata <= ram_rdata;
            mem_valid <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int LAT  = 2;
  localparam int SMAX = 3;

  logic        clock, reset;
  logic        if_req, if_valid, if_stall;
  logic [15:0] if_addr, if_rdata;
  logic        mem_req, mem_we, mem_valid, mem_stall;
  logic [1:0]  mem_byte_en;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        ram_en, ram_we;
  logic [1:0]  ram_byte_en;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;

  logic        l1_if_req, l1_if_valid, l1_if_stall;
  logic [15:0] l1_if_addr, l1_if_rdata;
  logic        l1_mem_req, l1_mem_we, l1_mem_valid, l1_mem_stall;
  logic [1:0]  l1_mem_byte_en;
  logic [15:0] l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
  logic        l1_ram_en, l1_ram_we;
  logic [1:0]  l1_ram_byte_en;
  logic [15:0] l1_ram_addr, l1_ram_wdata, l1_ram_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte_en(mem_byte_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_stall(mem_stall),
    .ram_en(ram_en), .ram_we(ram_we), .ram_byte_en(ram_byte_en), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata));

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .STARVE_MAX(SMAX)) dut_l1 (
    .clock(clock), .reset(reset),
    .if_req(l1_if_req), .if_addr(l1_if_addr), .if_rdata(l1_if_rdata), .if_valid(l1_if_valid),
    .if_stall(l1_if_stall),
    .mem_req(l1_mem_req), .mem_we(l1_mem_we), .mem_byte_en(l1_mem_byte_en), .mem_addr(l1_mem_addr),
    .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata), .mem_valid(l1_mem_valid),
    .mem_stall(l1_mem_stall),
    .ram_en(l1_ram_en), .ram_we(l1_ram_we), .ram_byte_en(l1_ram_byte_en), .ram_addr(l1_ram_addr),
    .ram_wdata(l1_ram_wdata), .ram_rdata(l1_ram_rdata));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] init_val(input int i);
    return 16'(i) ^ 16'hC35A;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = old;
    if (be[0]) r[7:0] = wd[7:0];
    if (be[1]) r[15:8] = wd[15:8];
    return r;
  endfunction

  // RAM device models: byte-lane writes, fixed-latency registered read pipe.
  logic [15:0] ram [0:65535];
  logic [15:0] rpipe0, rpipe1;
  always @(posedge clock) begin
    if (ram_en && ram_we) ram[ram_addr] = merge(ram[ram_addr], ram_wdata, ram_byte_en);
    rpipe1 <= rpipe0;
    rpipe0 <= ram[ram_addr];
  end
  assign ram_rdata = rpipe1;

  logic [15:0] l1_ram [0:255];
  logic [15:0] l1_pipe;
  always @(posedge clock) l1_pipe <= l1_ram[l1_ram_addr[7:0]];
  assign l1_ram_rdata = l1_pipe;

  // Reference memory for the random phase, updated from the bench's own requests.
  logic [15:0] ref_mem [0:255];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_fetch;
    logic        we;
    logic [1:0]  be;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  // One isolated access starting in an IDLE cycle (cycle 0); req drops the cycle after valid.
  task automatic do_access(input vec_t v, input string tag);
    int   en_cnt, vcyc;
    logic st, vl;
    en_cnt = 0;
    vcyc   = -1;
    if (v.is_fetch) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      mem_req = 1'b1; mem_we = v.we; mem_byte_en = v.be; mem_addr = v.addr; mem_wdata = v.wdata;
    end
    for (int c = 0; c < 20 && vcyc < 0; c++) begin
      @(negedge clock);
      if (ram_en) begin
        en_cnt++;
        chk({tag, " ram_en_cycle"}, c, 1);
        chk({tag, " ram_we"}, ram_we, v.is_fetch ? 1'b0 : v.we);
        chk({tag, " ram_byte_en"}, ram_byte_en, (v.is_fetch || !v.we) ? 2'b11 : v.be);
        chk({tag, " ram_addr"}, ram_addr, v.addr);
        if (!v.is_fetch && v.we) chk({tag, " ram_wdata"}, ram_wdata, v.wdata);
      end
      st = v.is_fetch ? if_stall : mem_stall;
      vl = v.is_fetch ? if_valid : mem_valid;
      chk($sformatf("%s stall_c%0d", tag, c), st, (c != v.exp_lat));
      if (vl) vcyc = c;
      else begin @(posedge clock); #1; end
    end
    chk({tag, " valid_cycle"}, vcyc, v.exp_lat);
    chk({tag, " ram_en_count"}, en_cnt, 1);
    if (v.is_fetch)  chk({tag, " if_rdata"}, if_rdata, v.exp_rdata);
    else if (!v.we)  chk({tag, " mem_rdata"}, mem_rdata, v.exp_rdata);
    @(posedge clock); #1;
    if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int    mv, iv, lv, cnt;
    int    en_c [$];
    logic [15:0] en_a [$];
    string order;
    bit    mvs, ivs, fin;
    bit    ip, mp, mw, g_ifp, prev_if;
    logic [15:0] ia, ma, mwd;
    logic [1:0]  mbe;
    int    en_cyc, en_since, run;

    reset = 1'b0;
    if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_byte_en = 0; mem_addr = 0; mem_wdata = 0;
    l1_if_req = 0; l1_if_addr = 0; l1_mem_req = 0; l1_mem_we = 0; l1_mem_byte_en = 0;
    l1_mem_addr = 0; l1_mem_wdata = 0;
    for (int i = 0; i < 65536; i++) ram[i] = init_val(i);
    for (int i = 0; i < 256; i++) begin l1_ram[i] = init_val(i); ref_mem[i] = init_val(i); end
    ram[16'h0004] = 16'hA123;
    ram[16'h0010] = 16'hFF00;

    // Reset state
    #1 reset = 1'b1;
    #1;
    chk("rst ram_en", ram_en, 0);       chk("rst ram_we", ram_we, 0);
    chk("rst ram_byte_en", ram_byte_en, 0); chk("rst ram_addr", ram_addr, 0);
    chk("rst ram_wdata", ram_wdata, 0); chk("rst if_rdata", if_rdata, 0);
    chk("rst mem_rdata", mem_rdata, 0); chk("rst if_valid", if_valid, 0);
    chk("rst mem_valid", mem_valid, 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Table-driven isolated accesses
    vecs[0] = '{1'b1, 1'b0, 2'b00, 16'h0004, 16'h0000, 16'hA123, 4};
    vecs[1] = '{1'b0, 1'b1, 2'b01, 16'h0010, 16'h55AA, 16'h0000, 2};
    vecs[2] = '{1'b0, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'hFFAA, 4};
    vecs[3] = '{1'b0, 1'b1, 2'b10, 16'h0011, 16'h1234, 16'h0000, 2};
    vecs[4] = '{1'b0, 1'b0, 2'b01, 16'h0011, 16'h0000, 16'h124B, 4};
    vecs[5] = '{1'b0, 1'b1, 2'b11, 16'h0012, 16'hBEEF, 16'h0000, 2};
    vecs[6] = '{1'b1, 1'b0, 2'b00, 16'h0012, 16'h0000, 16'hBEEF, 4};
    vecs[7] = '{1'b0, 1'b0, 2'b10, 16'h0013, 16'h0000, 16'hC349, 4};
    for (int i = 0; i < 8; i++) do_access(vecs[i], $sformatf("vec%0d", i));

    // Simultaneous requests: data first, IF after the bubble
    if_req = 1; if_addr = 16'h0030; mem_req = 1; mem_we = 0; mem_addr = 16'h0020;
    mv = -1; iv = -1;
    for (int c = 0; c < 30 && iv < 0; c++) begin
      @(negedge clock);
      if (ram_en) begin en_c.push_back(c); en_a.push_back(ram_addr); end
      if (mem_valid) begin mv = c; chk("sim mem_rdata", mem_rdata, init_val(16'h20)); end
      if (if_valid)  begin iv = c; chk("sim if_rdata", if_rdata, init_val(16'h30)); end
      @(posedge clock); #1;
      if (mv == c) mem_req = 0;
      if (iv == c) if_req = 0;
    end
    chk("sim mem_valid_cycle", mv, 4);
    chk("sim if_valid_cycle", iv, 9);
    chk("sim grant_count", en_c.size(), 2);
    if (en_c.size() == 2) begin
      chk("sim d_issue_cycle", en_c[0], 1); chk("sim d_issue_addr", en_a[0], 16'h0020);
      chk("sim i_issue_cycle", en_c[1], 6); chk("sim i_issue_addr", en_a[1], 16'h0030);
    end

    // Starvation: data held continuously, IF pending
    if_req = 1; if_addr = 16'h0030; mem_req = 1; mem_we = 0; mem_addr = 16'h0020;
    order = ""; fin = 0;
    for (int c = 0; c < 80 && !fin; c++) begin
      @(negedge clock);
      if (ram_en && order.len() < 5) order = {order, (ram_addr == 16'h0030) ? "I" : "D"};
      mvs = mem_valid; ivs = if_valid;
      @(posedge clock); #1;
      if (ivs) if_req = 0;
      if (mvs && order.len() >= 5) begin mem_req = 0; fin = 1; end
    end
    checks++;
    if (order != "DDDID") begin
      errors++;
      $display("FAIL starve_order: got %s expected DDDID", order);
    end
    chk("starve finished", fin, 1);
    mem_req = 0; if_req = 0;

    // Reset in WAIT_I
    if_req = 1; if_addr = 16'h0004;
    @(posedge clock); #1;
    @(posedge clock); #1;
    #2 reset = 1; if_req = 0;
    #1;
    chk("rmid ram_en", ram_en, 0);       chk("rmid ram_addr", ram_addr, 0);
    chk("rmid if_rdata", if_rdata, 0);   chk("rmid mem_rdata", mem_rdata, 0);
    chk("rmid if_valid", if_valid, 0);   chk("rmid ram_byte_en", ram_byte_en, 0);
    @(posedge clock); @(posedge clock); #1;
    reset = 0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (if_valid) cnt++;
      @(posedge clock); #1;
    end
    chk("rmid ghost_if_valid", cnt, 0);
    do_access(vecs[0], "rmid refetch");

    // MEM_LAT=1 build
    l1_if_req = 1; l1_if_addr = 16'h0005; lv = -1;
    for (int c = 0; c < 12 && lv < 0; c++) begin
      @(negedge clock);
      if (l1_ram_en) chk("lat1 ram_en_cycle", c, 1);
      if (l1_if_valid) lv = c;
      else begin @(posedge clock); #1; end
    end
    chk("lat1 valid_cycle", lv, 3);
    chk("lat1 if_rdata", l1_if_rdata, init_val(5));
    @(posedge clock); #1;
    l1_if_req = 0;

    // Randomized traffic against the transaction-level reference
    ip = 0; mp = 0; run = 0; en_since = 0; en_cyc = 0; prev_if = 0; g_ifp = 0;
    ia = 0; ma = 0; mwd = 0; mbe = 0; mw = 0;
    for (int c = 0; c < 600; c++) begin
      if (!ip) begin
        if_req = 0;
        if (c < 560 && $urandom_range(0, 2) == 0) begin
          ip = 1; ia = 16'h0040 + 16'($urandom_range(0, 15)); if_req = 1; if_addr = ia;
        end
      end
      if (!mp) begin
        mem_req = 0;
        if (c < 560 && $urandom_range(0, 1) == 0) begin
          mp = 1; ma = 16'h0040 + 16'($urandom_range(0, 15)); mw = 1'($urandom_range(0, 1));
          mbe = 2'($urandom_range(0, 3)); mwd = 16'($urandom);
          mem_req = 1; mem_we = mw; mem_addr = ma; mem_byte_en = mbe; mem_wdata = mwd;
        end
      end
      @(negedge clock);
      if (ram_en) begin
        en_since++; en_cyc = c; g_ifp = prev_if;
        if (!ram_we) chk("rnd read_byte_en", ram_byte_en, 2'b11);
      end
      if (if_valid) begin
        chk($sformatf("rnd if_rdata@%0h", ia), if_rdata, ref_mem[ia[7:0]]);
        chk("rnd if_latency", c - en_cyc, LAT + 1);
        chk("rnd if_one_access", en_since, 1);
        en_since = 0; run = 0; ip = 0;
      end
      if (mem_valid) begin
        if (mw) ref_mem[ma[7:0]] = merge(ref_mem[ma[7:0]], mwd, mbe);
        else chk($sformatf("rnd mem_rdata@%0h", ma), mem_rdata, ref_mem[ma[7:0]]);
        chk("rnd mem_latency", c - en_cyc, mw ? 1 : LAT + 1);
        chk("rnd mem_one_access", en_since, 1);
        en_since = 0;
        run = g_ifp ? run + 1 : 0;
        chk("rnd starve_bound", (run <= SMAX), 1);
        mp = 0;
      end
      prev_if = if_req;
      @(posedge clock); #1;
    end
    chk("rnd drained", {ip, mp}, 2'b00);
    if_req = 0; mem_req = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified RAM between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Grants one access at a time and sequences the RAM through its fixed read latency.
- Returns fetched data to the correct requester.
- Drives per-requester stall lines that feed the hazard unit's pc_stop / IF-ID hold and the pipeline freeze.

Parameters:
- ADDR_W, 16, RAM word-address width.
- DATA_W, 16, RAM data width.
- MEM_LAT, 2, cycles from ram_en cycle to valid ram_rdata. Must be >=1; elaboration error otherwise.
- STARVE_MAX, 3, consecutive data grants allowed while if_req is pending before IF is forced.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  IF read request; held until if_valid.
- if_addr  in  ADDR_W  fetch address; stable while if_req.
- if_rdata  out  DATA_W  fetched instruction; registered, held until next IF completion.
- if_valid  out  1  one-cycle completion pulse for IF.
- if_stall  out  1  if_req & ~if_valid (combinational).
- mem_req  in  1  data request; held until mem_valid.
- mem_we  in  1  1 = store, 0 = load.
- mem_byte_en  in  2  byte lanes for stores.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load data; registered, held.
- mem_valid  out  1  one-cycle completion pulse for data.
- mem_stall  out  1  mem_req & ~mem_valid (combinational).
- ram_en  out  1  RAM access strobe, exactly one cycle per access.
- ram_we  out  1  RAM write enable; only high with ram_en.
- ram_byte_en  out  2  RAM byte lanes. Forced 2'b11 for reads.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.

Behaviour:
- Reset (async, any state):
  - state=IDLE, starve_cnt=0.
  - ram_en/ram_we/if_valid/mem_valid=0.
  - ram_addr/ram_wdata/if_rdata/mem_rdata=0, ram_byte_en=0.
  - Any in-flight access is abandoned. No valid pulse is emitted after reset deasserts.
- FSM states: IDLE, ISSUE_I, ISSUE_D, WAIT_I, WAIT_D. All RAM outputs are registered.
- IDLE arbitration, sampled at the edge ending the IDLE cycle:
  - Eligible = req high and that requester's valid not high this cycle. Its request is already consumed.
  - Data has priority. Exception: if both are eligible and starve_cnt==STARVE_MAX, IF wins.
  - Winner's address, data and controls are latched. Next state is ISSUE_I or ISSUE_D.
- starve_cnt:
  - +1 (saturating) on each data grant while if_req is high.
  - Cleared on an IF grant, or when if_req is low at a data grant.
- ISSUE_x: ram_en=1 for exactly this cycle.
  - Store: next state IDLE, and mem_valid pulses in the following cycle.
  - Load/fetch: next state WAIT_x with a wait count of MEM_LAT.
- WAIT_x:
  - The counter decrements each cycle.
  - In the cycle where ram_rdata is valid (MEM_LAT cycles after the ISSUE cycle), the data is captured at the edge.
  - At that edge: x_rdata is updated, x_valid pulses the next cycle, and state goes to IDLE.
- Latency with MEM_LAT=2, request first seen in IDLE at cycle 0:
  - Read: ram_en in cycle 1, capture at end of cycle 3, valid in cycle 4 (4 cycles).
  - Store: ram_en in cycle 1, mem_valid in cycle 2.
- Bubbles and overlap:
  - One IDLE cycle between accesses (the valid cycle).
  - No overlap; one outstanding access max.
- Requester rule (protocol): deassert or change a request only in the cycle after x_valid.
- A request that drops before valid is a protocol violation and is not checked. The access still completes and the valid pulse is still emitted.

Decomposition:
- Shared package cpu_defs holds:
  - the arbiter state encoding (IDLE..WAIT_D);
  - ADDR_W/DATA_W defaults;
  - the read byte-enable constant 2'b11.
- One sub-module: arb_wait_counter. It is loaded with MEM_LAT in ISSUE and asserts done at zero.

Test Plan:
- Single fetch:
  - Stimulus: if_req=1, if_addr=16'h0004, RAM[4]=16'hA123.
  - Required: ram_en only in cycle 1, if_valid in cycle 4, if_rdata=16'hA123.
  - if_stall high in cycles 0-3 and low in cycle 4.
- Store then load:
  - Store: mem_we=1, addr 16'h0010, wdata 16'h55AA, byte_en 2'b01. Required: ram_we=1 and ram_byte_en=2'b01 in cycle 1, mem_valid in cycle 2.
  - Then a load of 16'h0010 (the RAM model applies byte lanes, prior content 16'hFF00). Required: mem_rdata=16'hFFAA.
- Simultaneous requests:
  - Stimulus: if_req and mem_req rise in the same cycle.
  - Required: data is issued first, mem_valid in cycle 4. IF is issued in cycle 6, if_valid in cycle 9.
- Starvation:
  - Stimulus: if_req held while mem_req is re-asserted continuously.
  - Required: exactly STARVE_MAX=3 data grants, then an IF grant, then data resumes.
- Reset mid-access:
  - Stimulus: reset asserted in the WAIT_I cycle, released 2 cycles later.
  - Required: all outputs are 0 immediately (async). No if_valid pulse ever appears for the aborted access. A fresh if_req completes normally.
- MEM_LAT=1 build:
  - Required: fetch completes with if_valid in cycle 3.
